// File: rtl/axis_eth_fcs_check_64.sv
// Receive-side FCS checker for a 64-bit AXI stream: verifies CRC-32, strips the 4-byte FCS.
// Optional runt-length check is enabled by defining AXIS_ETH_FCS_CHECK_RUNT_EN.
module axis_eth_fcs_check_64 #(
    parameter int unsigned MIN_FRAME_LENGTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic        error_bad_fcs,
    output logic        error_runt
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LAST} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready_en;
    logic [63:0] r_h_data;
    logic [7:0]  r_h_keep;
    logic        r_h_user;
    logic        r_h_bad;
    logic        r_h_runt;
    logic [31:0] r_crc;
    logic [63:0] r_m_tdata;
    logic [7:0]  r_m_tkeep;
    logic        r_m_tvalid;
    logic        r_m_tlast;
    logic        r_m_tuser;
    logic        r_busy;
    logic        r_err_fcs;
    logic        r_err_runt;

    logic        w_out_free;
    logic        w_fire;
    logic [3:0]  w_k;
    logic        w_short;
    logic [31:0] w_crc_new;
    logic        w_bad;
    logic        w_runt;
    logic        w_final_user;
    logic        w_out_load;
    logic [63:0] w_out_data;
    logic [7:0]  w_out_keep;
    logic        w_out_last;
    logic        w_out_user;
    logic        w_h_load;
    logic [7:0]  w_h_keep;
    logic        w_pulse_fcs;
    logic        w_pulse_runt;
    logic        w_busy_next;

    // Reflected CRC-32, LSB-first, applied only over the enabled bytes of the beat.
    function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [63:0] d,
                                               input logic [7:0] keep);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (keep[i]) begin
                for (int b = 0; b < 8; b++) begin
                    fb = r[0] ^ d[8*i+b];
                    r  = (r >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
                end
            end
        end
        return r;
    endfunction

    assign w_out_free    = !r_m_tvalid || m_axis_tready;
    assign s_axis_tready = r_ready_en && (r_state != S_LAST) && w_out_free;
    assign w_fire        = s_axis_tvalid && s_axis_tready;
    assign w_short       = (w_k <= 4'd4);
    assign w_crc_new     = crc_update((r_state == S_IDLE) ? 32'hFFFFFFFF : r_crc,
                                      s_axis_tdata, s_axis_tkeep);
    assign w_bad         = (w_crc_new != CRC_RESIDUE);
    assign w_final_user  = s_axis_tuser | w_bad | w_runt;

    always_comb begin
        w_k = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_k = w_k + {3'd0, s_axis_tkeep[i]};
        end
    end

`ifdef AXIS_ETH_FCS_CHECK_RUNT_EN
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_base;
    logic [16:0] w_cnt_sum;
    logic [15:0] w_cnt_new;

    assign w_cnt_base = (r_state == S_IDLE) ? 16'd0 : r_cnt;
    assign w_cnt_sum  = {1'b0, w_cnt_base} + {13'd0, w_k};
    assign w_cnt_new  = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    assign w_runt     = (32'(w_cnt_new) < MIN_FRAME_LENGTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (w_fire) begin
            r_cnt <= w_cnt_new;
        end
    end
`else
    assign w_runt = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_out_load   = 1'b0;
        w_out_data   = r_h_data;
        w_out_keep   = 8'hFF;
        w_out_last   = 1'b0;
        w_out_user   = 1'b0;
        w_h_load     = 1'b0;
        w_h_keep     = 8'hFF;
        w_pulse_fcs  = 1'b0;
        w_pulse_runt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (!s_axis_tlast) begin
                        w_h_load     = 1'b1;
                        w_state_next = S_HOLD;
                    end else if (w_short) begin
                        // Nothing but (part of) an FCS: no payload to forward.
                        w_pulse_fcs  = 1'b1;
                        w_pulse_runt = w_runt;
                    end else begin
                        w_out_load   = 1'b1;
                        w_out_data   = s_axis_tdata;
                        w_out_keep   = s_axis_tkeep >> 4;
                        w_out_last   = 1'b1;
                        w_out_user   = w_final_user;
                        w_pulse_fcs  = w_bad;
                        w_pulse_runt = w_runt;
                    end
                end
            end
            S_HOLD: begin
                if (w_fire) begin
                    w_out_load = 1'b1;
                    if (!s_axis_tlast) begin
                        w_h_load = 1'b1;
                    end else if (w_short) begin
                        // The FCS spills back into H: trim its top bytes.
                        w_out_keep   = 8'hFF >> (4'd4 - w_k);
                        w_out_last   = 1'b1;
                        w_out_user   = w_final_user;
                        w_pulse_fcs  = w_bad;
                        w_pulse_runt = w_runt;
                        w_state_next = S_IDLE;
                    end else begin
                        w_h_load     = 1'b1;
                        w_h_keep     = s_axis_tkeep >> 4;
                        w_state_next = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (w_out_free) begin
                    w_out_load   = 1'b1;
                    w_out_keep   = r_h_keep;
                    w_out_last   = 1'b1;
                    w_out_user   = r_h_user;
                    w_pulse_fcs  = r_h_bad;
                    w_pulse_runt = r_h_runt;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_next = r_busy;
        if (r_m_tvalid && m_axis_tready && r_m_tlast) begin
            w_busy_next = 1'b0;
        end
        if (w_fire && (r_state == S_IDLE) && !(s_axis_tlast && w_short)) begin
            w_busy_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready_en <= 1'b0;
            r_h_data   <= 64'd0;
            r_h_keep   <= 8'd0;
            r_h_user   <= 1'b0;
            r_h_bad    <= 1'b0;
            r_h_runt   <= 1'b0;
            r_crc      <= 32'hFFFFFFFF;
            r_m_tdata  <= 64'd0;
            r_m_tkeep  <= 8'd0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            r_busy     <= 1'b0;
            r_err_fcs  <= 1'b0;
            r_err_runt <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready_en <= 1'b1;
            r_busy     <= w_busy_next;
            r_err_fcs  <= w_pulse_fcs;
            r_err_runt <= w_pulse_runt;
            if (w_fire) begin
                r_crc <= w_crc_new;
            end
            if (w_h_load) begin
                r_h_data <= s_axis_tdata;
                r_h_keep <= w_h_keep;
                r_h_user <= w_final_user;
                r_h_bad  <= w_bad;
                r_h_runt <= w_runt;
            end
            if (w_out_load) begin
                r_m_tdata  <= w_out_data;
                r_m_tkeep  <= w_out_keep;
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_out_last;
                r_m_tuser  <= w_out_user;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;
    assign busy          = r_busy;
    assign error_bad_fcs = r_err_fcs;
    assign error_runt    = r_err_runt;

endmodule
